rtc_lectura_seq: RTL and testbench
==================================

Name: rtc_lectura_seq

Overview:
- Upstream feeder of the time/date/timer register bank.
- Sweeps the external RTC chip's nine registers (hora, min, seg, dia, mes, ano, crhora, crmin, crseg) over the multiplexed address/data bus.
- Places each byte on dato_bus and pulses the matching one-hot enable, so the bank latches all nine values in one sweep.

Parameters:
- T_WAIT, 4, clk cycles per bus phase; legal range 1..255.
- REFRESH_PERIOD, 1000000, clk cycles between automatic sweeps; used only with RTC_AUTO_REFRESH_EN.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle request for a full 9-register sweep
- ad_in  in  8  RTC AD bus, read path
- ad_out  out  8  RTC AD bus, write path (address)
- ad_oe  out  1  1 = drive ad_out onto the AD bus
- cs_n  out  1  RTC chip select, active low
- rd_n  out  1  RTC read strobe, active low
- wr_n  out  1  RTC write strobe, active low
- a_d  out  1  0 = address cycle, 1 = data cycle
- dato_bus  out  8  captured byte to the register bank
- en  out  9  one-hot load enables; bit i drives bank ENi
- busy  out  1  sweep in progress
- done  out  1  one-cycle pulse at sweep end

Behaviour:
- Reset values: cs_n=1, rd_n=1, wr_n=1, a_d=0, ad_oe=0, ad_out=0x00, dato_bus=0x00, en=0, busy=0, done=0, state IDLE, idx=0.
- Reset mid-sweep: next cycle has the bus released and no en pulse; any partial sweep is discarded.
- FSM states: IDLE, ADDR, GAP1, DATA, LOAD, GAP2. Phase counter cnt counts 0..T_WAIT-1.
- IDLE:
  - start=1 -> ADDR on the next edge with idx=0, busy=1.
  - start is ignored in every state except IDLE.
- ADDR (T_WAIT cycles): cs_n=0, wr_n=0, a_d=0, ad_oe=1, ad_out=ADDR_TBL[idx].
- GAP1 (T_WAIT cycles): cs_n=1, wr_n=1, ad_oe=0, a_d=1.
- DATA (T_WAIT cycles):
  - cs_n=0, rd_n=0, a_d=1, ad_oe=0.
  - On the edge ending the last DATA cycle, dato_bus <= ad_in.
- LOAD (1 cycle):
  - cs_n=1, rd_n=1, en = 1<<idx.
  - dato_bus stable; the bank latches on the edge ending LOAD.
- GAP2 (T_WAIT cycles): bus idle, en=0.
  - Exit with idx<8: idx+1 -> ADDR.
  - Exit with idx=8: -> IDLE, busy=0, done=1 for that first IDLE cycle.
- Sweep length: 9*(4*T_WAIT+1) cycles with busy=1.
- dato_bus holds its last captured value between captures.
- en is never multi-hot; ad_oe=1 only in ADDR (no bus contention).
- Address order/values (idx 0..8): 0x23, 0x22, 0x21, 0x24, 0x25, 0x26, 0x43, 0x42, 0x41.

Optional Feature:
- Macro: RTC_AUTO_REFRESH_EN.
- Defined:
  - A free-running counter of REFRESH_PERIOD cycles issues an internal start when it wraps.
  - If busy at wrap, that refresh is dropped (no queuing).
  - External start is still honoured in IDLE.
  - The counter resets to 0 on reset.
- Undefined: no counter logic; sweeps occur only on start.

Decomposition:
- Package rtc_pkg holds:
  - state enum;
  - index constants IDX_HORA..IDX_CRSEG (0..8);
  - ADDR_TBL of the nine 8-bit addresses;
  - NUM_REGS=9.
- One natural sub-module: rtc_bus_phase_timer, the T_WAIT phase counter with load/expire.

Test Plan:
- Reset then idle -> all outputs at reset values; no bus activity for 100 cycles.
- T_WAIT=2, start pulse, model returns 0x12,0x34,0x56,0x07,0x08,0x16,0x01,0x02,0x03 -> en bits 0..8 pulse in order with matching dato_bus; done at cycle 82 after start; busy high exactly 81 cycles.
- Bus timing check, T_WAIT=2 -> ad_out=0x23 with cs_n=wr_n=0 for 2 cycles; then a 2-cycle gap; then rd_n=0 for 2 cycles; ad_oe=0 whenever rd_n=0.
- start re-pulsed mid-sweep -> ignored; exactly 9 en pulses and one done.
- reset asserted during DATA of idx=4 -> next cycle cs_n=rd_n=1, en=0, busy=0; a new start restarts at address 0x23.
- RTC_AUTO_REFRESH_EN with REFRESH_PERIOD=200, T_WAIT=1 -> sweeps begin every 200 cycles without start; a wrap coinciding with an external-start sweep adds no extra sweep.

Source files
------------

// File: rtl/rtc_lectura_seq_pkg.sv
// Shared types and constants for the RTC read sequencer: FSM states, register indices and bus addresses.
package rtc_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      ADDR = 3'd1,
      GAP1 = 3'd2,
      DATA = 3'd3,
      LOAD = 3'd4,
      GAP2 = 3'd5
   } state_t;

   localparam int NUM_REGS = 9;

   localparam logic [3:0] IDX_HORA   = 4'd0;
   localparam logic [3:0] IDX_MIN    = 4'd1;
   localparam logic [3:0] IDX_SEG    = 4'd2;
   localparam logic [3:0] IDX_DIA    = 4'd3;
   localparam logic [3:0] IDX_MES    = 4'd4;
   localparam logic [3:0] IDX_ANO    = 4'd5;
   localparam logic [3:0] IDX_CRHORA = 4'd6;
   localparam logic [3:0] IDX_CRMIN  = 4'd7;
   localparam logic [3:0] IDX_CRSEG  = 4'd8;

   // Element i is the RTC address read at sweep step i (0x23 first, 0x41 last).
   localparam logic [NUM_REGS-1:0][7:0] ADDR_TBL = {
      8'h41, 8'h42, 8'h43, 8'h26, 8'h25, 8'h24, 8'h21, 8'h22, 8'h23
   };

endpackage

// File: rtl/rtc_bus_phase_timer.sv
// Bus phase timer: counts 0..T_WAIT-1 while run is high; expire flags the last cycle of a phase.
// load parks the count at 0 so every timed phase starts from a clean count.
module rtc_bus_phase_timer #(
   parameter int T_WAIT = 4
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   input  logic run,
   output logic expire
);

   localparam logic [7:0] LAST = 8'(T_WAIT - 1);

   logic [7:0] cnt;

   assign expire = run && (cnt == LAST);

   always_ff @(posedge clk) begin
      if (reset || load) begin
         cnt <= 8'd0;
      end else if (run) begin
         cnt <= expire ? 8'd0 : cnt + 8'd1;
      end
   end

endmodule

// File: rtl/rtc_lectura_seq.sv
// Sweeps the nine RTC registers over the multiplexed AD bus and hands each byte to the bank with a one-hot enable.
// A sweep is 9*(4*T_WAIT+1) busy cycles; RTC_AUTO_REFRESH_EN adds a periodic internal start.
import rtc_pkg::*;

module rtc_lectura_seq #(
   parameter int T_WAIT = 4
`ifdef RTC_AUTO_REFRESH_EN
   ,
   parameter int REFRESH_PERIOD = 1000000
`endif
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                start,
   input  logic [7:0]          ad_in,
   output logic [7:0]          ad_out,
   output logic                ad_oe,
   output logic                cs_n,
   output logic                rd_n,
   output logic                wr_n,
   output logic                a_d,
   output logic [7:0]          dato_bus,
   output logic [NUM_REGS-1:0] en,
   output logic                busy,
   output logic                done
);

   state_t     state, state_nxt;
   logic [3:0] idx;
   logic       run, expire, go;
   logic       last_reg;
   logic       done_r;
   logic [7:0] dato_r;

   assign run      = (state == ADDR) || (state == GAP1) || (state == DATA) || (state == GAP2);
   assign last_reg = (idx == IDX_CRSEG);

   rtc_bus_phase_timer #(
      .T_WAIT (T_WAIT)
   ) u_timer (
      .clk    (clk),
      .reset  (reset),
      .load   (!run),
      .run    (run),
      .expire (expire)
   );

`ifdef RTC_AUTO_REFRESH_EN
   logic [31:0] rcnt;
   logic        wrap;

   assign wrap = (rcnt == 32'(REFRESH_PERIOD - 1));

   always_ff @(posedge clk) begin
      if (reset) begin
         rcnt <= 32'd0;
      end else begin
         rcnt <= wrap ? 32'd0 : rcnt + 32'd1;
      end
   end

   // A wrap while busy is simply lost: only IDLE looks at go.
   assign go = start || wrap;
`else
   assign go = start;
`endif

   always_comb begin
      state_nxt = state;
      cs_n      = 1'b1;
      rd_n      = 1'b1;
      wr_n      = 1'b1;
      a_d       = 1'b0;
      ad_oe     = 1'b0;
      ad_out    = 8'h00;
      en        = '0;
      case (state)
         IDLE: begin
            if (go) state_nxt = ADDR;
         end
         ADDR: begin
            cs_n   = 1'b0;
            wr_n   = 1'b0;
            ad_oe  = 1'b1;
            ad_out = ADDR_TBL[idx];
            if (expire) state_nxt = GAP1;
         end
         GAP1: begin
            a_d = 1'b1;
            if (expire) state_nxt = DATA;
         end
         DATA: begin
            cs_n = 1'b0;
            rd_n = 1'b0;
            a_d  = 1'b1;
            if (expire) state_nxt = LOAD;
         end
         LOAD: begin
            en        = 9'd1 << idx;
            state_nxt = GAP2;
         end
         GAP2: begin
            if (expire) state_nxt = last_reg ? IDLE : ADDR;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         idx    <= 4'd0;
         dato_r <= 8'h00;
         done_r <= 1'b0;
      end else begin
         state  <= state_nxt;
         done_r <= (state == GAP2) && expire && last_reg;
         if (state == IDLE) begin
            idx <= 4'd0;
         end else if ((state == GAP2) && expire && !last_reg) begin
            idx <= idx + 4'd1;
         end
         // Sample the RTC on the edge that closes the read strobe window.
         if ((state == DATA) && expire) begin
            dato_r <= ad_in;
         end
      end
   end

   assign dato_bus = dato_r;
   assign busy     = (state != IDLE);
   assign done     = done_r;

endmodule

// File: tb/tb_rtc_lectura_seq.sv
// Randomized bench for rtc_lectura_seq with a behavioural RTC chip and a cycle-offset reference model.
module tb_rtc_lectura_seq;

`ifdef RTC_AUTO_REFRESH_EN
   localparam int TW   = 1;
   localparam int RP   = 200;
   localparam bit AUTO = 1'b1;
`else
   localparam int TW   = 2;
   localparam int RP   = 1000;
   localparam bit AUTO = 1'b0;
`endif
   localparam int PER = 4 * TW + 1;
   localparam int LEN = 9 * PER;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [7:0] ad_in;
   logic [7:0] ad_out;
   logic       ad_oe, cs_n, rd_n, wr_n, a_d, busy, done;
   logic [7:0] dato_bus;
   logic [8:0] en;

   rtc_lectura_seq #(
      .T_WAIT (TW)
`ifdef RTC_AUTO_REFRESH_EN
      ,
      .REFRESH_PERIOD (RP)
`endif
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .start    (start),
      .ad_in    (ad_in),
      .ad_out   (ad_out),
      .ad_oe    (ad_oe),
      .cs_n     (cs_n),
      .rd_n     (rd_n),
      .wr_n     (wr_n),
      .a_d      (a_d),
      .dato_bus (dato_bus),
      .en       (en),
      .busy     (busy),
      .done     (done)
   );

   always #5 clk = ~clk;

   // Behavioural RTC chip: latches the address on write strobe, returns mem[addr] on read.
   logic [7:0] mem [256];
   logic [7:0] chip_addr = 8'h00;
   always @(posedge clk) if (!cs_n && !wr_n && ad_oe) chip_addr <= ad_out;
   assign ad_in = (!cs_n && !rd_n) ? mem[chip_addr] : 8'hEE;

   logic [7:0] atbl [9] = '{8'h23, 8'h22, 8'h21, 8'h24, 8'h25, 8'h26, 8'h43, 8'h42, 8'h41};
   logic [7:0] fixv [9] = '{8'h12, 8'h34, 8'h56, 8'h07, 8'h08, 8'h16, 8'h01, 8'h02, 8'h03};

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Reference model: k is the offset into the current sweep, -1 when idle.
   int         k = -1;
   logic       done_e = 1'b0;
   logic [7:0] dato_e = 8'h00;
   int         rcnt = 0;

   always @(posedge clk) begin
      bit wrap;
      bit d;
      cyc++;
      wrap = AUTO && (rcnt == RP - 1);
      d = 1'b0;
      if (reset) begin
         k = -1;
         dato_e = 8'h00;
         rcnt = 0;
      end else begin
         rcnt = wrap ? 0 : rcnt + 1;
         if (k >= 0) begin
            if (k % PER == 3 * TW - 1) dato_e = mem[atbl[k / PER]];
            if (k == LEN - 1) begin
               k = -1;
               d = 1'b1;
            end else begin
               k++;
            end
         end else if (start || wrap) begin
            k = 0;
         end
      end
      done_e = d;
   end

   // Packed {cs_n,rd_n,wr_n,a_d,ad_oe,ad_out,en,busy} expected at sweep offset kk.
   function automatic logic [31:0] exp_bus(input int kk);
      logic cs, rd, wr, ad, oe, b;
      logic [7:0] ao;
      logic [8:0] e;
      cs = 1'b1; rd = 1'b1; wr = 1'b1; ad = 1'b0; oe = 1'b0; b = 1'b0;
      ao = 8'h00; e = 9'h000;
      if (kk >= 0) begin
         int i;
         int p;
         i = kk / PER;
         p = kk % PER;
         b = 1'b1;
         if (p < TW) begin
            cs = 1'b0; wr = 1'b0; oe = 1'b1; ao = atbl[i];
         end else if (p < 2 * TW) begin
            ad = 1'b1;
         end else if (p < 3 * TW) begin
            cs = 1'b0; rd = 1'b0; ad = 1'b1;
         end else if (p == 3 * TW) begin
            e[i] = 1'b1;
         end
      end
      return 32'({cs, rd, wr, ad, oe, ao, e, b});
   endfunction

   bit   mon_on = 1'b0;
   logic busy_q = 1'b0;
   int   en_cnt = 0, done_cnt = 0, busy_cnt = 0, done_cyc = 0, start_cyc = 0;
   int   starts[$];

   always @(negedge clk) begin
      if (mon_on) begin
         chk("bus", 32'({cs_n, rd_n, wr_n, a_d, ad_oe, ad_out, en, busy}), exp_bus(k));
         chk("done", 32'(done), 32'(done_e));
         chk("dato", 32'(dato_bus), 32'(dato_e));
         if (en != 9'h000) en_cnt++;
         if (done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (busy) busy_cnt++;
         if (busy && !busy_q) starts.push_back(cyc);
         busy_q = busy;
      end
   end

   task automatic clear_cnt();
      en_cnt = 0;
      done_cnt = 0;
      busy_cnt = 0;
   endtask

   task automatic fill_regs(input bit fixed);
      for (int i = 0; i < 9; i++) mem[atbl[i]] = fixed ? fixv[i] : 8'($urandom);
   endtask

   task automatic pulse_start();
      @(negedge clk);
      start = 1'b1;
      start_cyc = cyc;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_k(input int target, input int budget);
      for (int n = 0; n < budget && k != target; n++) @(negedge clk);
      chk("wait_k", 32'(k), 32'(target));
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int a = 0; a < 256; a++) mem[a] = 8'($urandom);
      reset = 1'b1;
      start = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_bus", 32'({cs_n, rd_n, wr_n, a_d, ad_oe, ad_out}), 32'({5'b11100, 8'h00}));
      chk("rst_en", 32'(en), 32'h0);
      chk("rst_busy_done", 32'({busy, done}), 32'h0);
      chk("rst_dato", 32'(dato_bus), 32'h0);
      mon_on = 1'b1;
      reset = 1'b0;
      clear_cnt();
      repeat (100) @(negedge clk);
      chk("idle_busy", 32'(busy_cnt), 32'h0);

      if (!AUTO) begin
         fill_regs(1'b1);
         clear_cnt();
         pulse_start();
         repeat (LEN + 4) @(negedge clk);
         chk("sw1_en", 32'(en_cnt), 32'd9);
         chk("sw1_busy", 32'(busy_cnt), 32'(LEN));
         chk("sw1_done", 32'(done_cnt), 32'd1);
         chk("sw1_done_lat", 32'(done_cyc - start_cyc), 32'(LEN + 1));
         chk("sw1_last_dato", 32'(dato_bus), 32'h03);

         for (int r = 0; r < 3; r++) begin
            fill_regs(1'b0);
            clear_cnt();
            pulse_start();
            wait_k(int'($urandom_range(1, LEN - 2)), LEN);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (LEN) @(negedge clk);
            chk("restart_en", 32'(en_cnt), 32'd9);
            chk("restart_done", 32'(done_cnt), 32'd1);
         end

         fill_regs(1'b0);
         pulse_start();
         wait_k(4 * PER + 2 * TW, LEN);
         reset = 1'b1;
         @(negedge clk);
         chk("rmid_strobes", 32'({cs_n, rd_n}), 32'h3);
         chk("rmid_en", 32'(en), 32'h0);
         chk("rmid_busy", 32'(busy), 32'h0);
         reset = 1'b0;
         clear_cnt();
         pulse_start();
         chk("rmid_addr0", 32'(ad_out), 32'h23);
         repeat (LEN + 4) @(negedge clk);
         chk("rmid_en_cnt", 32'(en_cnt), 32'd9);
      end else begin
         starts.delete();
         repeat (650) @(negedge clk);
         chk("auto_n", 32'(starts.size() >= 3), 32'd1);
         for (int i = 1; i < starts.size(); i++)
            chk("auto_gap", 32'(starts[i] - starts[i-1]), 32'(RP));
         fill_regs(1'b0);
         for (int n = 0; n < 400 && rcnt != 170; n++) @(negedge clk);
         chk("ext_idle", 32'(busy), 32'h0);
         clear_cnt();
         start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         repeat (120) @(negedge clk);
         chk("ext_done", 32'(done_cnt), 32'd1);
         chk("ext_busy", 32'(busy_cnt), 32'(LEN));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
